// File: rtl/uart_frame_tx.sv
// Byte-frame sequencer for uart_tx: header, NBYTES snapshotted payload bytes, optional checksum.
// Define UART_FRAME_CS_EN to append the mod-256 checksum byte to every frame.
module uart_frame_tx #(
  parameter int         NBYTES  = 9,
  parameter logic [7:0] HEADER  = 8'h5A,
  parameter int         GAP     = 16,
  parameter bit         AUTO    = 1'b0,
  parameter int         ACK_TMO = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                frame_req,
  input  logic [8*NBYTES-1:0] payload,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                frame_busy,
  output logic                frame_done,
  output logic                frame_err
);

  localparam int IDX_W = $clog2(NBYTES + 2);
  localparam int TMO_W = $clog2(ACK_TMO + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ACK   = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [8*NBYTES-1:0]   payload_q;
  logic                  snap;
  logic [7:0]            pay_byte;
`ifdef UART_FRAME_CS_EN
  logic [7:0]            cs_q, cs_d;
`endif

  // Payload byte selected by the current index (next byte to send is payload[idx]).
  always_comb begin
    pay_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (IDX_W'(k) == idx_q) pay_byte = payload_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    snap       = 1'b0;
`ifdef UART_FRAME_CS_EN
    cs_d       = cs_q;
`endif
    case (state_q)
      S_IDLE, S_ACK: begin
        state_d = S_IDLE;
        if (en && (AUTO || frame_req)) begin
          snap       = 1'b1;
          tx_data_d  = HEADER;
          tx_start_d = 1'b1;
          idx_d      = '0;
          tmo_d      = '0;
          busy_d     = 1'b1;
`ifdef UART_FRAME_CS_EN
          cs_d       = HEADER;
`endif
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = S_DRAIN;
        end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          busy_d     = 1'b0;
          gap_d      = '0;
          state_d    = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          tmo_d = '0;
          if (idx_q < IDX_W'(NBYTES)) begin
            idx_d      = idx_q + 1'b1;
            tx_data_d  = pay_byte;
            tx_start_d = 1'b1;
`ifdef UART_FRAME_CS_EN
            cs_d       = cs_q + pay_byte;
`endif
            state_d    = S_START;
          end
`ifdef UART_FRAME_CS_EN
          else if (idx_q == IDX_W'(NBYTES)) begin
            idx_d      = idx_q + 1'b1;
            tx_data_d  = cs_q;
            tx_start_d = 1'b1;
            state_d    = S_START;
          end
`endif
          else begin
            // Last byte drained: index stays put so it never wraps.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            gap_d   = '0;
            state_d = (GAP == 0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_FRAME_CS_EN
      cs_q       <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef UART_FRAME_CS_EN
      cs_q       <= cs_d;
`endif
    end
  end

  // Snapshot is plain data: no reset needed.
  always_ff @(posedge clk) begin
    if (snap) payload_q <= payload;
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
